hilo_unit: RTL and testbench
============================

// Module: hilo_unit
// PURPOSE
//   Downstream consumer of the ALU's multiply/divide outputs (HI_wr, LO_wr, HI_result, LO_result).
//   Holds the architectural HI/LO registers and models multi-cycle mul/div latency with a countdown.
//   Serves mfhi/mflo/mthi/mtlo and raises a stall to the pipeline while a result is pending.
// PARAMETERS
//   MUL_LAT  4   cycles from mul/mulu issue to HI/LO commit (>=1)
//   DIV_LAT  32  cycles from div/divu issue to HI/LO commit (>=1)
//   CNT_W    6   countdown width; must hold max(MUL_LAT,DIV_LAT)-1
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   issue_i      in   1   EX stage holds a valid mul/div this cycle (qualifies ALU flags)
//   is_div_i     in   1   1: div/divu latency, 0: mul/mulu latency
//   hi_wr_i      in   1   ALU HI_wr
//   lo_wr_i      in   1   ALU LO_wr
//   hi_res_i     in   32  ALU HI_result
//   lo_res_i     in   32  ALU LO_result
//   mthi_i       in   1   move-to-HI request
//   mtlo_i       in   1   move-to-LO request
//   mt_data_i    in   32  rs value for mthi/mtlo
//   mfhi_i       in   1   move-from-HI request
//   mflo_i       in   1   move-from-LO request
//   flush_i      in   1   abort pending op (exception/branch squash)
//   rd_data_o    out  32  HI (mfhi) or LO (mflo); 0 when neither is requested
//   stall_o      out  1   freeze upstream stages this cycle
//   busy_o       out  1   an op is pending (state BUSY)
//   hi_o, lo_o   out  32  architectural HI/LO (debug/trace)
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): state=IDLE; HI, LO, shadow regs, counter = 0; busy_o=0; stall_o=0.
//   FSM: IDLE, BUSY.
//   - IDLE & issue_i & (hi_wr_i|lo_wr_i): latch hi_res_i/lo_res_i and both write flags into shadow regs;
//     cnt <= (is_div_i ? DIV_LAT : MUL_LAT) - 1; go to BUSY. With LAT=1, commit on the next edge.
//   - BUSY, cnt!=0: cnt <= cnt-1. BUSY, cnt==0: commit HI if shadow hi_wr, LO if shadow lo_wr; go to IDLE.
//   - issue_i with both write flags 0: ignored.
//   stall_o is combinational and equals BUSY & (issue_i|mthi_i|mtlo_i|mfhi_i|mflo_i).
//     Stalled requests are not consumed; the requester holds them until stall_o drops.
//   mthi/mtlo in IDLE write HI/LO at the clock edge. mfhi/mflo in IDLE read the current register.
//     Issue and mt* in the same IDLE cycle: mt* commits now; the issued op overwrites it at its own commit.
//   mfhi & mflo together: mfhi wins. mthi & mfhi together: rd_data_o returns the old HI.
//   flush_i: highest priority. BUSY -> IDLE with no commit; HI/LO unchanged. flush_i in IDLE drops
//     same-cycle issue/mt*. stall_o = 0 while flush_i = 1.
//   Counter never wraps: it is only loaded in IDLE and only decremented while it is nonzero.
//   Reset during BUSY: pending op is lost; HI/LO = 0.
// CONFIGURATION
//   HILO_BYPASS_EN defined: in the commit cycle (BUSY, cnt==0), mfhi/mflo are not stalled.
//     rd_data_o forwards the shadow value if that half is being committed, else the current register.
//   Undefined: any mf* request in the commit cycle stalls one extra cycle, then reads the register.
// STRUCTURE
//   hilo_pkg: state enum (IDLE/BUSY), default MUL_LAT/DIV_LAT constants, 32-bit word typedef.
//   Sub-module hilo_lat_counter: load/decrement/zero-flag countdown of width CNT_W.
//   Top level holds the FSM, shadow regs, HI/LO regs, read mux and stall logic.
// TESTING
//   1 reset, then mfhi_i=1 -> rd_data_o=0, stall_o=0, hi_o=lo_o=0.
//   2 issue mul, hi=32'h1, lo=32'h2, MUL_LAT=4, mfhi held -> stall_o=1 for 4 cycles, then rd=1; lo_o=2.
//   3 issue div, hi=7, lo=9; flush_i on cycle 10 -> busy_o=0 next cycle; HI/LO keep prior values.
//   4 mthi 32'hDEAD in IDLE, mflo next cycle -> hi_o=DEAD, rd_data_o=old LO; mthi+mfhi same cycle -> old HI.
//   5 issue div and assert rst_n=0 at cycle 5 -> outputs 0 at once; after release, mflo -> rd 0.
//   6 HILO_BYPASS_EN, mul hi=3, lo=4, mflo in commit cycle -> stall_o=0, rd=4; undefined -> 1 extra stall.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared state encoding, default latencies and word type for the HI/LO unit.
package hilo_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/hilo_lat_counter.sv
// hilo_lat_counter: loadable countdown that saturates at zero and flags when it gets there.
module hilo_lat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_cnt <= '0;
        else if (load_i)
            r_cnt <= load_val_i;
        else if (dec_i && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    assign zero_o = (r_cnt == '0);
endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO registers with multi-cycle mul/div commit, mf/mt access and stall.
// Define HILO_BYPASS_EN to forward the committing result to mfhi/mflo instead of stalling.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_i,
    input  logic        is_div_i,
    input  logic        hi_wr_i,
    input  logic        lo_wr_i,
    input  word_t       hi_res_i,
    input  word_t       lo_res_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  word_t       mt_data_i,
    input  logic        mfhi_i,
    input  logic        mflo_i,
    input  logic        flush_i,
    output word_t       rd_data_o,
    output logic        stall_o,
    output logic        busy_o,
    output word_t       hi_o,
    output word_t       lo_o
);
    state_t r_state, w_state_nxt;
    word_t  r_hi, r_lo, r_sh_hi, r_sh_lo, w_hi_nxt, w_lo_nxt, w_hi_rd, w_lo_rd;
    logic   r_sh_hi_wr, r_sh_lo_wr;
    logic   w_idle, w_busy, w_zero, w_accept, w_commit, w_mt_ok, w_mf_blk;

    assign w_idle   = (r_state == IDLE);
    assign w_busy   = (r_state == BUSY);
    assign w_accept = w_idle && issue_i && (hi_wr_i || lo_wr_i) && !flush_i;
    assign w_commit = w_busy && w_zero && !flush_i;
    assign w_mt_ok  = w_idle && !flush_i;

    hilo_lat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_accept),
        .load_val_i (is_div_i ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1)),
        .dec_i      (w_busy),
        .zero_o     (w_zero)
    );

    always_comb begin
        w_state_nxt = flush_i ? IDLE : w_accept ? BUSY : w_commit ? IDLE : r_state;
        w_hi_nxt = (w_commit && r_sh_hi_wr) ? r_sh_hi : (w_mt_ok && mthi_i) ? mt_data_i : r_hi;
        w_lo_nxt = (w_commit && r_sh_lo_wr) ? r_sh_lo : (w_mt_ok && mtlo_i) ? mt_data_i : r_lo;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state    <= IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_sh_hi    <= '0;
            r_sh_lo    <= '0;
            r_sh_hi_wr <= 1'b0;
            r_sh_lo_wr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_accept) begin
                r_sh_hi    <= hi_res_i;
                r_sh_lo    <= lo_res_i;
                r_sh_hi_wr <= hi_wr_i;
                r_sh_lo_wr <= lo_wr_i;
            end
        end

`ifdef HILO_BYPASS_EN
    // commit cycle: reads see the value about to land instead of waiting a cycle
    assign w_mf_blk = !w_zero;
    assign w_hi_rd  = (w_commit && r_sh_hi_wr) ? r_sh_hi : r_hi;
    assign w_lo_rd  = (w_commit && r_sh_lo_wr) ? r_sh_lo : r_lo;
`else
    assign w_mf_blk = 1'b1;
    assign w_hi_rd  = r_hi;
    assign w_lo_rd  = r_lo;
`endif

    assign stall_o   = !flush_i && w_busy && (issue_i || mthi_i || mtlo_i || ((mfhi_i || mflo_i) && w_mf_blk));
    assign rd_data_o = mfhi_i ? w_hi_rd : mflo_i ? w_lo_rd : '0;
    assign busy_o    = w_busy;
    assign hi_o      = r_hi;
    assign lo_o      = r_lo;
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: scoreboard bench for hilo_unit; mf reads queue their expected value and
// pop it when the unit stops stalling.
module tb_hilo_unit;
    logic        clk = 0, rst_n = 0;
    logic        issue_i = 0, is_div_i = 0, hi_wr_i = 0, lo_wr_i = 0;
    logic [31:0] hi_res_i = 0, lo_res_i = 0, mt_data_i = 0;
    logic        mthi_i = 0, mtlo_i = 0, mfhi_i = 0, mflo_i = 0, flush_i = 0;
    logic [31:0] rd_data_o, hi_o, lo_o;
    logic        stall_o, busy_o;
    logic [31:0] q_exp[$];
    int          n_vec = 0, n_err = 0, stalls;

`ifdef HILO_BYPASS_EN
    localparam int EXP_T2_STALLS = 3;
    localparam int EXP_T6_STALLS = 0;
`else
    localparam int EXP_T2_STALLS = 4;
    localparam int EXP_T6_STALLS = 1;
`endif

    hilo_unit dut (
        .clk(clk), .rst_n(rst_n), .issue_i(issue_i), .is_div_i(is_div_i),
        .hi_wr_i(hi_wr_i), .lo_wr_i(lo_wr_i), .hi_res_i(hi_res_i), .lo_res_i(lo_res_i),
        .mthi_i(mthi_i), .mtlo_i(mtlo_i), .mt_data_i(mt_data_i),
        .mfhi_i(mfhi_i), .mflo_i(mflo_i), .flush_i(flush_i),
        .rd_data_o(rd_data_o), .stall_o(stall_o), .busy_o(busy_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit div, input bit hw, input bit lw, input logic [31:0] h, input logic [31:0] l);
        issue_i = 1; is_div_i = div; hi_wr_i = hw; lo_wr_i = lw; hi_res_i = h; lo_res_i = l;
        cyc();
        issue_i = 0; hi_wr_i = 0; lo_wr_i = 0;
    endtask

    task automatic read(input string tag, input bit hi, input logic [31:0] exp, output int n_st);
        bit got = 0;
        mfhi_i = hi; mflo_i = !hi;
        q_exp.push_back(exp);
        n_st = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!stall_o) begin
                got = 1;
                break;
            end
            n_st++;
            cyc();
        end
        if (got)
            chk(tag, rd_data_o, q_exp.pop_front());
        else begin
            void'(q_exp.pop_front());
            chk({tag, "_timeout"}, n_st, 0);
        end
        cyc();
        mfhi_i = 0; mflo_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) cyc();
        rst_n = 1;
        // reset state
        @(negedge clk);
        chk("t1_hi", hi_o, 0);
        chk("t1_lo", lo_o, 0);
        chk("t1_busy", busy_o, 0);
        cyc();
        read("t1_mfhi", 1, 0, stalls);
        chk("t1_stalls", stalls, 0);

        // mul commit with held mfhi
        issue(0, 1, 1, 32'h1, 32'h2);
        chk("t2_busy", busy_o, 1);
        read("t2_mfhi", 1, 32'h1, stalls);
        chk("t2_stalls", stalls, EXP_T2_STALLS);
        chk("t2_lo", lo_o, 32'h2);

        // div aborted by flush
        issue(1, 1, 1, 32'h7, 32'h9);
        repeat (8) cyc();
        flush_i = 1; mfhi_i = 1;
        @(negedge clk);
        chk("t3_flush_stall", stall_o, 0);
        chk("t3_flush_rd", rd_data_o, 32'h1);
        cyc();
        flush_i = 0; mfhi_i = 0;
        chk("t3_busy", busy_o, 0);
        chk("t3_hi", hi_o, 32'h1);
        chk("t3_lo", lo_o, 32'h2);
        flush_i = 1;
        issue(0, 1, 1, 32'h5, 32'h6);
        flush_i = 0;
        chk("t3_idle_flush_busy", busy_o, 0);

        // mthi / mfhi interactions
        mthi_i = 1; mt_data_i = 32'hDEAD;
        @(negedge clk);
        chk("t4_mthi_stall", stall_o, 0);
        cyc();
        mthi_i = 0;
        chk("t4_hi", hi_o, 32'hDEAD);
        read("t4_mflo", 0, 32'h2, stalls);
        mthi_i = 1; mfhi_i = 1; mt_data_i = 32'hBEEF;
        @(negedge clk);
        chk("t4_mthi_mfhi_rd", rd_data_o, 32'hDEAD);
        cyc();
        mthi_i = 0; mfhi_i = 0;
        chk("t4_hi2", hi_o, 32'hBEEF);
        issue(0, 0, 0, 32'h11, 32'h22);
        chk("t4_noflag_busy", busy_o, 0);
        mtlo_i = 1; mt_data_i = 32'h55;
        issue(0, 0, 1, 32'h77, 32'h66);
        mtlo_i = 0;
        chk("t4_mtlo_now", lo_o, 32'h55);
        chk("t4_mtlo_busy", busy_o, 1);
        read("t4_lo_commit", 0, 32'h66, stalls);
        chk("t4_hi_kept", hi_o, 32'hBEEF);

        // asynchronous reset mid-op
        issue(1, 1, 1, 32'hA, 32'hB);
        repeat (4) cyc();
        rst_n = 0;
        #1;
        chk("t5_busy", busy_o, 0);
        chk("t5_hi", hi_o, 0);
        chk("t5_lo", lo_o, 0);
        chk("t5_stall", stall_o, 0);
        cyc();
        rst_n = 1;
        read("t5_mflo", 0, 0, stalls);

        // mflo arriving in the commit cycle
        issue(0, 1, 1, 32'h3, 32'h4);
        repeat (3) cyc();
        read("t6_mflo", 0, 32'h4, stalls);
        chk("t6_stalls", stalls, EXP_T6_STALLS);
        chk("t6_hi", hi_o, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
